// File: rtl/load_store_unit.sv
// Load/store unit: bridges the MEM stage to a word-wide data memory.
// Handles byte/half/word loads and stores with lane steering, sign/zero
// extension, range and encoding faults. Word-crossing accesses are split
// into two memory beats when LSU_MISALIGN_SPLIT_EN is defined; otherwise
// they fault without touching memory.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  func3_ex,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic        stall,
  output logic        done,
  output logic [31:0] readdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, lo_word_q;
  logic [2:0]  f3_q;
  logic        store_q, fault_q;

  logic        req_in, f3_ok, illegal_in, range_in, cross_in, fault_in;
  logic [2:0]  size_in;
  logic [32:0] end_in;
  logic        cross_q;
  logic [3:0]  be_base;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide, ld_wide, ld_shift;
  logic        ld_finish;

  function automatic logic [2:0] acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [31:0] b);
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b001:  return {{16{b[15]}}, b[15:0]};
      3'b100:  return {24'b0, b[7:0]};
      3'b101:  return {16'b0, b[15:0]};
      default: return b;
    endcase
  endfunction

  // Request decode and fault classification of the incoming access
  always_comb begin
    req_in  = valid_in & (memread | memwrite);
    size_in = acc_size(func3_ex);
    case (func3_ex)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = memread;
      default:                f3_ok = 1'b0;
    endcase
    illegal_in = (memread & memwrite) | ~f3_ok;
    end_in     = {1'b0, address} + {30'b0, size_in};
    range_in   = end_in > 33'(MEM_BYTES);
    cross_in   = ({2'b00, address[1:0]} + {1'b0, size_in}) > 4'd4;
`ifdef LSU_MISALIGN_SPLIT_EN
    fault_in   = illegal_in | range_in;
`else
    fault_in   = illegal_in | range_in | cross_in;
`endif
  end

  // Captured access crosses into the next word (only reachable when split is enabled)
`ifdef LSU_MISALIGN_SPLIT_EN
  assign cross_q = ({2'b00, addr_q[1:0]} + {1'b0, acc_size(f3_q)}) > 4'd4;
`else
  assign cross_q = 1'b0;
`endif

  // Lane steering: 64-bit view spanning the accessed word and the next one
  always_comb begin
    case (f3_q[1:0])
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be_wide   = {4'b0000, be_base} << addr_q[1:0];
    wd_wide   = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
    ld_wide   = (state_q == ACC1) ? {mem_rdata, lo_word_q} : {32'b0, mem_rdata};
    ld_shift  = ld_wide >> {addr_q[1:0], 3'b000};
    ld_finish = ~store_q & mem_ready &
                (((state_q == ACC0) & ~cross_q) | (state_q == ACC1));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_in) state_d = fault_in ? DONE : ACC0;
      ACC0: if (mem_ready) state_d = cross_q ? ACC1 : DONE;
      ACC1: if (mem_ready) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: memory beat drive, handshake and status pulses
  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (state_q)
      IDLE: stall = req_in;
      ACC0: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        if (store_q) begin
          mem_we    = 1'b1;
          mem_be    = be_wide[3:0];
          mem_wdata = wd_wide[31:0];
        end else begin
          mem_be    = 4'b1111;
        end
      end
      ACC1: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
        if (store_q) begin
          mem_we    = 1'b1;
          mem_be    = be_wide[7:4];
          mem_wdata = wd_wide[63:32];
        end else begin
          mem_be    = 4'b1111;
        end
      end
      DONE: begin
        done  = ~fault_q;
        fault = fault_q;
      end
      default: ;
    endcase
  end

  assign readdata = rdata_q;

  // Access capture, low-word buffering for split loads, and load result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      fault_q   <= 1'b0;
      lo_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (state_q == IDLE && req_in) begin
        addr_q  <= address;
        wdata_q <= writedata;
        f3_q    <= func3_ex;
        store_q <= memwrite;
        fault_q <= fault_in;
      end
      if (state_q == ACC0 && mem_ready && cross_q && !store_q)
        lo_word_q <= mem_rdata;
      if (ld_finish)
        rdata_q <= fmt_load(f3_q, ld_shift[31:0]);
    end
  end

endmodule
